pwm_bank: RTL

- N-channel PWM generator sharing one period counter.
- Each channel has a runtime-programmable duty and phase offset.
- Optional per-channel AND gating with channel 0 produces burst/modulated outputs, generalising the fixed-parameter two-PWM arrangement.
- Sits between the top-level control logic (button/LED/AVR side) and the external signal pins; all settings are written through a simple register-write port.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_channel.sv | 65 ++++++
 rtl/pwm_bank.sv | 92 +++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM bank: register field codes and phase arithmetic.
// Latency: none (package only).
// Backpressure: none (package only).
package pwm_pkg;

    localparam logic [1:0] FIELD_DUTY   = 2'd0;
    localparam logic [1:0] FIELD_OFFSET = 2'd1;
    localparam logic [1:0] FIELD_PERIOD = 2'd2;

    // Widest supported counter; callers zero-extend into wide_t and truncate the result.
    localparam int MAX_W = 32;
    typedef logic [MAX_W:0] wide_t;

    // Modular distance from the channel's offset to the counter within one period.
    // The extra bit keeps cnt + period + 1 from overflowing when period is all ones.
    function automatic wide_t phase_sub(input wide_t cnt, input wide_t off, input wide_t per);
        if (cnt >= off) begin
            return cnt - off;
        end
        return cnt + per + wide_t'(1) - off;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty/offset and raw waveform from the shared counter.
// Latency: raw is combinational from cnt and the shadow registers.
// Backpressure: none; writes are always accepted, loads happen on the shared strobe.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_duty,
    input  logic             wr_off,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             load,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] period_sh,
    output logic             raw
);

    localparam int W1 = WIDTH + 1;

    logic [WIDTH-1:0] duty_stg_q, duty_stg_d;
    logic [WIDTH-1:0] duty_sh_q,  duty_sh_d;
    logic [WIDTH-1:0] off_stg_q,  off_stg_d;
    logic [WIDTH-1:0] off_sh_q,   off_sh_d;
    logic [WIDTH-1:0] off_eff;
    logic [W1-1:0]    phase;

    // Staging takes writes immediately; shadows copy staging only on the load strobe.
    always_comb begin
        duty_stg_d = duty_stg_q;
        off_stg_d  = off_stg_q;
        duty_sh_d  = duty_sh_q;
        off_sh_d   = off_sh_q;
        if (wr_duty) duty_stg_d = wr_data;
        if (wr_off)  off_stg_d  = wr_data;
        if (load) begin
            duty_sh_d = duty_stg_q;
            off_sh_d  = off_stg_q;
        end
    end

    // Register state; reset clears both buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_stg_q <= '0;
            duty_sh_q  <= '0;
            off_stg_q  <= '0;
            off_sh_q   <= '0;
        end else begin
            duty_stg_q <= duty_stg_d;
            duty_sh_q  <= duty_sh_d;
            off_stg_q  <= off_stg_d;
            off_sh_q   <= off_sh_d;
        end
    end

    // Offsets beyond the period fall back to zero; high while phase is below duty.
    always_comb begin
        off_eff = (off_sh_q <= period_sh) ? off_sh_q : '0;
        phase   = W1'(phase_sub(wide_t'(cnt), wide_t'(off_eff), wide_t'(period_sh)));
        raw     = (phase < {1'b0, duty_sh_q});
    end

endmodule

// File: rtl/pwm_bank.sv
// N-channel PWM bank on one shared period counter with double-buffered settings and gating.
// Latency: pwm_out/period_start registered, one cycle after the counter value producing them.
// Backpressure: none; one register write accepted every cycle, out-of-range writes dropped.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int               CHANNELS   = 4,
    parameter int               WIDTH      = 8,
    parameter int               CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter logic [WIDTH-1:0] RST_PERIOD = {WIDTH{1'b1}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                wr_en,
    input  logic [1:0]          wr_field,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [CHANNELS-1:0] gate_mask,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    period_stg_q, period_stg_d;
    logic [WIDTH-1:0]    period_sh_q, period_sh_d;
    logic [CHANNELS-1:0] pwm_out_q, pwm_out_d;
    logic                period_start_q, period_start_d;
    logic                boundary;
    logic                load;
    logic [CHANNELS-1:0] raw;

    assign boundary = enable && (cnt_q == period_sh_q);
    // While idle the shadows track staging so the first enabled cycle uses fresh settings.
    assign load     = boundary || !enable;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            pwm_channel #(.WIDTH(WIDTH)) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .wr_duty   (wr_en && (wr_field == FIELD_DUTY)   && (wr_ch == CH_W'(gi))),
                .wr_off    (wr_en && (wr_field == FIELD_OFFSET) && (wr_ch == CH_W'(gi))),
                .wr_data   (wr_data),
                .load      (load),
                .cnt       (cnt_q),
                .period_sh (period_sh_q),
                .raw       (raw[gi])
            );
        end
    endgenerate

    // Counter, period buffering, gating and output staging.
    always_comb begin
        cnt_d          = '0;
        period_stg_d   = period_stg_q;
        period_sh_d    = period_sh_q;
        pwm_out_d      = '0;
        period_start_d = 1'b0;
        if (enable && !boundary) cnt_d = cnt_q + WIDTH'(1);
        if (wr_en && (wr_field == FIELD_PERIOD)) period_stg_d = wr_data;
        if (load) period_sh_d = period_stg_q;
        if (enable) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out_d[i] = raw[i] & (gate_mask[i] ? raw[0] : 1'b1);
            end
            period_start_d = (cnt_q == '0);
        end
    end

    // State registers; reset restarts the period from zero with default period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            period_stg_q   <= RST_PERIOD;
            period_sh_q    <= RST_PERIOD;
            pwm_out_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            period_stg_q   <= period_stg_d;
            period_sh_q    <= period_sh_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;

endmodule
